// File: rtl/encoder_pkg.sv
// Shared widths and helper functions for the 8-to-3 priority encoder block.
package encoder_pkg;

    localparam int IDX_W = 3;
    localparam int REQ_W = 8;

    function automatic logic [REQ_W-1:0] onehot8(input logic [IDX_W-1:0] idx);
        onehot8 = 8'h01 << idx;
    endfunction

    // Later loop iterations overwrite earlier ones, so the scan order sets the winner.
    function automatic logic [IDX_W-1:0] prio_enc8(input logic [REQ_W-1:0] vec,
                                                   input logic high_first);
        logic [IDX_W-1:0] result;
        result = 3'd0;
        if (high_first) begin
            for (int i = 0; i < REQ_W; i++) begin
                result = vec[i] ? IDX_W'(i) : result;
            end
        end else begin
            for (int i = REQ_W - 1; i >= 0; i--) begin
                result = vec[i] ? IDX_W'(i) : result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/priority_encoder_8_3.sv
// Combinational fixed-priority encoder: request vector to winning index plus any-set flag.
module priority_encoder_8_3
    import encoder_pkg::*;
#(
    parameter logic HIGH_FIRST = 1'b1
) (
    input  logic [REQ_W-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    assign idx = prio_enc8(vec, HIGH_FIRST);
    assign any = |vec;

endmodule

// File: rtl/encoder_8_3.sv
// Registered 8-to-3 priority encoder with sticky pending bits, valid/ack output
// handshake and a one-cycle overflow pulse when an event merges into a pending bit.
module encoder_8_3
    import encoder_pkg::*;
#(
    parameter logic HIGH_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [REQ_W-1:0] inp,
    input  logic             ack,
    output logic [IDX_W-1:0] out,
    output logic             out_valid,
    output logic [REQ_W-1:0] pending,
    output logic             overflow
);

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PRESENT = 1'b1;

    logic [REQ_W-1:0] pending_r;
    logic [IDX_W-1:0] out_r;
    logic             out_valid_r;
    logic             overflow_r;

    logic             hs_s;
    logic [REQ_W-1:0] clr_s;
    logic [REQ_W-1:0] set_s;
    logic [REQ_W-1:0] pending_n_s;
    logic             ovf_s;
    logic [IDX_W-1:0] enc_idx_s;
    logic             enc_any_s;
    logic             valid_n_s;
    logic [IDX_W-1:0] out_n_s;

    // Handshake, clear/set masks and next pending value; set wins over clear.
    always_comb begin
        hs_s        = out_valid_r & ack;
        clr_s       = hs_s ? onehot8(out_r) : 8'h00;
        set_s       = enable ? inp : 8'h00;
        pending_n_s = (pending_r & ~clr_s) | set_s;
        ovf_s       = |(set_s & pending_r & ~clr_s);
    end

    priority_encoder_8_3 #(
        .HIGH_FIRST(HIGH_FIRST)
    ) u_prio (
        .vec(pending_n_s),
        .idx(enc_idx_s),
        .any(enc_any_s)
    );

    // Two-state presenter: a load happens when idle or on handshake, else out is frozen.
    always_comb begin
        valid_n_s = out_valid_r;
        out_n_s   = out_r;
        case (out_valid_r)
            ST_IDLE: begin
                if (enc_any_s) begin
                    valid_n_s = ST_PRESENT;
                    out_n_s   = enc_idx_s;
                end else begin
                    valid_n_s = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (hs_s && enc_any_s) begin
                    valid_n_s = ST_PRESENT;
                    out_n_s   = enc_idx_s;
                end else if (hs_s) begin
                    valid_n_s = ST_IDLE;
                end else begin
                    valid_n_s = ST_PRESENT;
                end
            end
            default: begin
                valid_n_s = ST_IDLE;
                out_n_s   = out_r;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r   <= 8'h00;
            out_r       <= 3'd0;
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            pending_r   <= pending_n_s;
            out_r       <= out_n_s;
            out_valid_r <= valid_n_s;
            overflow_r  <= ovf_s;
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign pending   = pending_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_encoder_8_3.sv
// Self-checking bench for encoder_8_3: vector table plus directed sequences,
// with expected results queued at drive time and popped after the clock edge.
module tb_encoder_8_3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hi_enable = 1'b0, lo_enable = 1'b0;
    logic [7:0] hi_inp = 8'h00, lo_inp = 8'h00;
    logic       hi_ack = 1'b0, lo_ack = 1'b0;
    logic [2:0] hi_out, lo_out;
    logic       hi_valid, lo_valid;
    logic [7:0] hi_pend, lo_pend;
    logic       hi_ovf, lo_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       enable;
        logic [7:0] inp;
        logic       ack;
        logic [2:0] out;
        logic       valid;
        logic [7:0] pend;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic       sel;
        logic [2:0] out;
        logic       valid;
        logic [7:0] pend;
        logic       ovf;
        string      name;
    } exp_t;

    vec_t tbl[25];
    exp_t sbq[$];

    encoder_8_3 #(.HIGH_FIRST(1'b1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .enable(hi_enable), .inp(hi_inp), .ack(hi_ack),
        .out(hi_out), .out_valid(hi_valid), .pending(hi_pend), .overflow(hi_ovf)
    );

    encoder_8_3 #(.HIGH_FIRST(1'b0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .enable(lo_enable), .inp(lo_inp), .ack(lo_ack),
        .out(lo_out), .out_valid(lo_valid), .pending(lo_pend), .overflow(lo_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle on the selected DUT, queue its expectation, compare after the edge.
    task automatic step(input logic sel, input vec_t v, input string name);
        exp_t e;
        exp_t got;
        if (sel) begin
            lo_enable = v.enable; lo_inp = v.inp; lo_ack = v.ack;
            hi_enable = 1'b0; hi_inp = 8'h00; hi_ack = 1'b0;
        end else begin
            hi_enable = v.enable; hi_inp = v.inp; hi_ack = v.ack;
            lo_enable = 1'b0; lo_inp = 8'h00; lo_ack = 1'b0;
        end
        e.sel = sel; e.out = v.out; e.valid = v.valid; e.pend = v.pend; e.ovf = v.ovf;
        e.name = name;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        if (got.sel) begin
            chk({got.name, ".out"},     {5'd0, lo_out},   {5'd0, got.out});
            chk({got.name, ".valid"},   {7'd0, lo_valid}, {7'd0, got.valid});
            chk({got.name, ".pending"}, lo_pend,          got.pend);
            chk({got.name, ".ovf"},     {7'd0, lo_ovf},   {7'd0, got.ovf});
        end else begin
            chk({got.name, ".out"},     {5'd0, hi_out},   {5'd0, got.out});
            chk({got.name, ".valid"},   {7'd0, hi_valid}, {7'd0, got.valid});
            chk({got.name, ".pending"}, hi_pend,          got.pend);
            chk({got.name, ".ovf"},     {7'd0, hi_ovf},   {7'd0, got.ovf});
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".hi_out"},   {5'd0, hi_out},   8'h00);
        chk({name, ".hi_valid"}, {7'd0, hi_valid}, 8'h00);
        chk({name, ".hi_pend"},  hi_pend,          8'h00);
        chk({name, ".hi_ovf"},   {7'd0, hi_ovf},   8'h00);
        chk({name, ".lo_out"},   {5'd0, lo_out},   8'h00);
        chk({name, ".lo_valid"}, {7'd0, lo_valid}, 8'h00);
        chk({name, ".lo_pend"},  lo_pend,          8'h00);
        chk({name, ".lo_ovf"},   {7'd0, lo_ovf},   8'h00);
    endtask

    initial begin
        vec_t v;

        //          en    inp    ack   out   valid pend   ovf
        tbl[0]  = '{1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0}; // idle after reset
        tbl[1]  = '{1'b1, 8'h20, 1'b0, 3'd5, 1'b1, 8'h20, 1'b0}; // single event
        tbl[2]  = '{1'b1, 8'h00, 1'b0, 3'd5, 1'b1, 8'h20, 1'b0}; // held
        tbl[3]  = '{1'b1, 8'h00, 1'b1, 3'd5, 1'b0, 8'h00, 1'b0}; // ack clears
        tbl[4]  = '{1'b1, 8'h91, 1'b0, 3'd7, 1'b1, 8'h91, 1'b0}; // drain start
        tbl[5]  = '{1'b1, 8'h00, 1'b1, 3'd4, 1'b1, 8'h11, 1'b0};
        tbl[6]  = '{1'b1, 8'h00, 1'b1, 3'd0, 1'b1, 8'h01, 1'b0};
        tbl[7]  = '{1'b1, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{1'b1, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0}; // ack while idle
        tbl[9]  = '{1'b1, 8'h04, 1'b0, 3'd2, 1'b1, 8'h04, 1'b0}; // no preemption
        tbl[10] = '{1'b1, 8'h80, 1'b0, 3'd2, 1'b1, 8'h84, 1'b0};
        tbl[11] = '{1'b1, 8'h00, 1'b0, 3'd2, 1'b1, 8'h84, 1'b0};
        tbl[12] = '{1'b1, 8'h00, 1'b1, 3'd7, 1'b1, 8'h80, 1'b0};
        tbl[13] = '{1'b1, 8'h00, 1'b1, 3'd7, 1'b0, 8'h00, 1'b0};
        tbl[14] = '{1'b1, 8'h08, 1'b0, 3'd3, 1'b1, 8'h08, 1'b0}; // set+clear same bit
        tbl[15] = '{1'b1, 8'h08, 1'b1, 3'd3, 1'b1, 8'h08, 1'b0};
        tbl[16] = '{1'b1, 8'h00, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0};
        tbl[17] = '{1'b1, 8'h04, 1'b0, 3'd2, 1'b1, 8'h04, 1'b0}; // overflow
        tbl[18] = '{1'b1, 8'h04, 1'b0, 3'd2, 1'b1, 8'h04, 1'b1};
        tbl[19] = '{1'b1, 8'h00, 1'b0, 3'd2, 1'b1, 8'h04, 1'b0};
        tbl[20] = '{1'b0, 8'hFF, 1'b0, 3'd2, 1'b1, 8'h04, 1'b0}; // enable low
        tbl[21] = '{1'b0, 8'hFF, 1'b1, 3'd2, 1'b0, 8'h00, 1'b0};
        tbl[22] = '{1'b1, 8'h03, 1'b0, 3'd1, 1'b1, 8'h03, 1'b0}; // merge during ack
        tbl[23] = '{1'b1, 8'h01, 1'b1, 3'd0, 1'b1, 8'h01, 1'b1};
        tbl[24] = '{1'b1, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};

        // Reset asserted with every request line high.
        rst_n = 1'b0;
        hi_enable = 1'b1; hi_inp = 8'hFF; lo_enable = 1'b1; lo_inp = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        hi_inp = 8'h00; lo_inp = 8'h00;
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            step(1'b0, tbl[i], $sformatf("vec%0d", i));
        end

        // Low-bit-first drain of the same burst.
        v = '{1'b1, 8'h91, 1'b0, 3'd0, 1'b1, 8'h91, 1'b0}; step(1'b1, v, "lo_drain0");
        v = '{1'b1, 8'h00, 1'b1, 3'd4, 1'b1, 8'h90, 1'b0}; step(1'b1, v, "lo_drain1");
        v = '{1'b1, 8'h00, 1'b1, 3'd7, 1'b1, 8'h80, 1'b0}; step(1'b1, v, "lo_drain2");
        v = '{1'b1, 8'h00, 1'b1, 3'd7, 1'b0, 8'h00, 1'b0}; step(1'b1, v, "lo_drain3");

        // Reset mid-operation discards pending events and the presented index.
        v = '{1'b1, 8'h60, 1'b0, 3'd6, 1'b1, 8'h60, 1'b0}; step(1'b0, v, "midrst_load");
        v = '{1'b1, 8'h60, 1'b0, 3'd6, 1'b1, 8'h60, 1'b1}; step(1'b0, v, "midrst_ovf");
        rst_n = 1'b0;
        #2;
        chk_all_zero("midrst");
        hi_inp = 8'h00; hi_enable = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v = '{1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0}; step(1'b0, v, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_8_3.md
# encoder_8_3

Registered 8-to-3 priority encoder with event capture and a valid/ack output handshake, the encoding counterpart to the team's 3-to-8 decoder. Each of eight request lines sets a sticky pending bit. The block reports the highest-priority pending index as a 3-bit code and holds it until a consumer acknowledges it; the acknowledged bit is then cleared. It sits between event sources (interrupt lines, status flags) and a consumer that services one index at a time, and typically drives a Decoder_3_8 select.

## Interface
- `HIGH_FIRST`, default 1: 1 = bit 7 highest priority; 0 = bit 0 highest priority.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  capture enable; when 0, `inp` is ignored.
- `inp`  in  8  request lines, sampled every cycle; each 1 is one event.
- `ack`  in  1  consumer accepts `out` when `out_valid` & `ack`.
- `out`  out  3  encoded index of the granted request.
- `out_valid`  out  1  `out` holds a pending, unacknowledged index.
- `pending`  out  8  current sticky pending register.
- `overflow`  out  1  one-cycle pulse: an event hit an already-pending bit and was merged.

## Operation
- Handshake `hs = out_valid & ack`. `clr = hs ? onehot(out) : 8'h00`. `set = enable ? inp : 8'h00`.
- `pending_n = (pending & ~clr) | set`. When set and clear hit the same bit in the same cycle, set wins and the bit stays pending.
- Overflow condition: `|(set & pending & ~clr)`. It is registered into `overflow` for exactly one cycle, and no event is counted.
- Output load, when `!out_valid | hs`:
  - if `pending_n != 0`: `out <= enc(pending_n)`, `out_valid <= 1`;
  - else: `out_valid <= 0`, and `out` holds its last value.
- While `out_valid & !ack`: `out` is frozen, even when a higher-priority bit arrives. Preemption happens only at the next load.
- `enc()` is a fixed-priority encoder selected by `HIGH_FIRST`. It is never evaluated on an all-zero vector when a load occurs.
- `enable = 0` does not stall the handshake. Draining continues and `pending` only shrinks.
- Only 2 states exist, encoded by `out_valid`: IDLE (0) and PRESENT (1).
  - IDLE→PRESENT when `pending_n != 0`.
  - PRESENT→PRESENT on `!hs`, or on `hs` with `pending_n != 0`.
  - PRESENT→IDLE on `hs` with `pending_n == 0`.
- `ack` while `out_valid = 0` has no effect.

## Timing
- Reset values (async assert, sync deassert by the system): `pending = 0`, `out = 0`, `out_valid = 0`, `overflow = 0`. Reset mid-operation discards all pending events and the presented index.
- Latency: an `inp` bit sampled at edge N, with the block idle, gives `pending` and `out_valid = 1` visible after edge N, i.e. 1 cycle.
- Back-to-back: on `hs`, the next index loads on the same edge. There are no bubble cycles, so the sustained throughput is one index per cycle.
- `overflow` asserts in the cycle after the offending sample.
- All outputs are registered. There is no combinational path from `inp` or `ack` to any output.

## Structure
- Shared package `encoder_pkg`:
  - `IDX_W = 3`, `REQ_W = 8`;
  - function `onehot8(idx)`;
  - function `prio_enc8(vec, high_first)`.
- Sub-module `priority_encoder_8_3` is purely combinational: `vec[7:0]` → `idx[2:0]` plus `any`, parameterised by `HIGH_FIRST`.
- The top level holds the pending register, the output register, and the overflow pulse.

## Test plan
- **Reset:** assert `rst_n = 0` with `inp = 8'hFF`, `enable = 1` → all outputs 0. Release, `inp = 0` → `out_valid` stays 0.
- **Single event:** `inp = 8'h20` for 1 cycle, `ack = 0` → next cycle `out = 5`, `out_valid = 1`, `pending = 8'h20`, held. Pulse `ack` → `pending = 0`, `out_valid = 0`.
- **Priority drain:** with `HIGH_FIRST = 1`, `inp = 8'h91` once, then `ack = 1` continuously → `out` sequence is 7, 4, 0 on consecutive cycles, then `out_valid = 0`. With `HIGH_FIRST = 0`, the same stimulus gives 0, 4, 7.
- **No preemption:** `out = 2` presented, `ack = 0`, then `inp = 8'h80` → `out` stays 2. After `ack`, the next `out` is 7.
- **Simultaneous set and clear:** with `out = 3` presented, assert `ack` and `inp = 8'h08` in the same cycle → `pending[3]` stays 1, `out = 3` is re-presented, and `overflow = 0`.
- **Overflow and enable:** `inp = 8'h04` twice while bit 2 is unacknowledged → `overflow` pulses once and `pending = 8'h04`. With `enable = 0` and `inp = 8'hFF` → `pending` is unchanged and `ack` still drains.
